// File: rtl/sc_busarb_pkg.sv
// Shared definitions for the bus arbiter: FSM state encoding and a
// constant clog2 helper used to size the hold counter and pointers.
package sc_busarb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } busArbState_t;

    // Ceiling log2 for elaboration-time sizing; returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int res;
        int rem;
        res = 0;
        rem = value - 1;
        while (rem > 0) begin
            res = res + 1;
            rem = rem >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/sc_busarb_rr_pick.sv
// Combinational round-robin picker: first request at or above startPtr,
// wrapping to index 0, ignoring any source set in excludeMask.
module sc_busarb_rr_pick #(
    parameter int NUM_SRC = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_SRC-1:0] reqVec,
    input  logic [PTR_W-1:0]   startPtr,
    input  logic [NUM_SRC-1:0] excludeMask,
    output logic [NUM_SRC-1:0] nextOneHot,
    output logic               found
);

    logic [NUM_SRC-1:0] cand_s;

    assign cand_s = reqVec & ~excludeMask;

    // Two passes: first the upper segment from startPtr, then the wrapped lower segment.
    always_comb begin : pick_blk
        logic hit;
        nextOneHot = {NUM_SRC{1'b0}};
        found      = 1'b0;
        hit        = 1'b0;
        for (int j = 0; j < NUM_SRC; j++) begin
            hit           = !found && cand_s[j] && (j >= int'(startPtr));
            nextOneHot[j] = hit;
            found         = found | hit;
        end
        for (int j = 0; j < NUM_SRC; j++) begin
            hit           = !found && cand_s[j] && (j < int'(startPtr));
            nextOneHot[j] = nextOneHot[j] | hit;
            found         = found | hit;
        end
    end

endmodule

// File: rtl/sc_bus_arbiter.sv
// Round-robin bus arbiter with registered grant, valid and bus data.
// A source keeps the bus for at most HOLD_MAX cycles while others wait.
// Optional feature macro: SC_BUSARB_PREEMPT_EN (source 0 preempts any owner).
module sc_bus_arbiter
    import sc_busarb_pkg::*;
#(
    parameter int DATAWIDTH_BUS = 32,
    parameter int NUM_SRC       = 4,
    parameter int HOLD_MAX      = 4
) (
    input  logic                             SC_BUSARB_CLOCK_50,
    input  logic                             SC_BUSARB_RESET_InLow,
    input  logic [NUM_SRC-1:0]               SC_BUSARB_Req_In,
    input  logic [NUM_SRC*DATAWIDTH_BUS-1:0] SC_BUSARB_Data_In,
    output logic [NUM_SRC-1:0]               SC_BUSARB_Grant_Out,
    output logic                             SC_BUSARB_Valid_Out,
    output logic [DATAWIDTH_BUS-1:0]         SC_BUSARB_DataBUS_Out
);

    localparam int PTR_W  = (clog2(NUM_SRC) < 1) ? 1 : clog2(NUM_SRC);
    localparam int HOLD_W = clog2(HOLD_MAX + 1);

    localparam logic [HOLD_W-1:0] HOLD_MAX_C = HOLD_W'(HOLD_MAX);
    localparam logic [HOLD_W-1:0] HOLD_ONE   = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_ZERO  = HOLD_W'(0);
    localparam logic [PTR_W-1:0]  LAST_IDX   = PTR_W'(NUM_SRC - 1);
    localparam logic [PTR_W-1:0]  PTR_ZERO   = PTR_W'(0);
    localparam logic [PTR_W-1:0]  PTR_ONE    = PTR_W'(1);

    busArbState_t              state_r, stateNext_s;
    logic [NUM_SRC-1:0]        grant_r, grantNext_s;
    logic [PTR_W-1:0]          owner_r, ownerNext_s;
    logic [PTR_W-1:0]          ptr_r, ptrNext_s;
    logic [HOLD_W-1:0]         hold_r, holdNext_s;
    logic                      valid_r, validNext_s;
    logic [DATAWIDTH_BUS-1:0]  data_r, dataNext_s;

    logic [PTR_W-1:0]          ownerPlusOne_s;
    logic [PTR_W-1:0]          pickPtr_s;
    logic [NUM_SRC-1:0]        pickExcl_s;
    logic [NUM_SRC-1:0]        pickOneHot_s;
    logic                      pickFound_s;
    logic [PTR_W-1:0]          pickIdx_s;
    logic                      ownerReq_s;
    logic                      otherReq_s;
    logic                      preemptHit_s;

`ifdef SC_BUSARB_PREEMPT_EN
    assign preemptHit_s = SC_BUSARB_Req_In[0] & ~grant_r[0];
`else
    assign preemptHit_s = 1'b0;
`endif

    // Search origin: after the current owner while granted, else from the round-robin pointer.
    always_comb begin
        ownerPlusOne_s = (owner_r == LAST_IDX) ? PTR_ZERO : owner_r + PTR_ONE;
        ownerReq_s     = |(SC_BUSARB_Req_In & grant_r);
        otherReq_s     = |(SC_BUSARB_Req_In & ~grant_r);
        if (state_r == ST_GRANT) begin
            pickPtr_s  = ownerPlusOne_s;
            pickExcl_s = grant_r;
        end else begin
            pickPtr_s  = ptr_r;
            pickExcl_s = {NUM_SRC{1'b0}};
        end
    end

    sc_busarb_rr_pick #(
        .NUM_SRC (NUM_SRC),
        .PTR_W   (PTR_W)
    ) u_rrPick (
        .reqVec      (SC_BUSARB_Req_In),
        .startPtr    (pickPtr_s),
        .excludeMask (pickExcl_s),
        .nextOneHot  (pickOneHot_s),
        .found       (pickFound_s)
    );

    // Encode the picker's one-hot result into an index (at most one bit is set).
    always_comb begin
        pickIdx_s = PTR_ZERO;
        for (int j = 0; j < NUM_SRC; j++) begin
            pickIdx_s = pickIdx_s | (pickOneHot_s[j] ? PTR_W'(j) : PTR_ZERO);
        end
    end

    // Next-state, grant, pointer and hold-counter decisions.
    always_comb begin
        stateNext_s = state_r;
        grantNext_s = grant_r;
        ownerNext_s = owner_r;
        ptrNext_s   = ptr_r;
        holdNext_s  = hold_r;
        case (state_r)
            ST_IDLE: begin
                if (pickFound_s) begin
                    stateNext_s = ST_GRANT;
                    grantNext_s = pickOneHot_s;
                    ownerNext_s = pickIdx_s;
                    holdNext_s  = HOLD_ONE;
                end else begin
                    stateNext_s = ST_IDLE;
                    grantNext_s = {NUM_SRC{1'b0}};
                    holdNext_s  = HOLD_ZERO;
                end
            end
            ST_GRANT: begin
                if (preemptHit_s) begin
                    // High-priority source takes over; pointer left untouched.
                    grantNext_s = {{(NUM_SRC-1){1'b0}}, 1'b1};
                    ownerNext_s = PTR_ZERO;
                    holdNext_s  = HOLD_ONE;
                end else if (!ownerReq_s) begin
                    ptrNext_s = ownerPlusOne_s;
                    if (pickFound_s) begin
                        grantNext_s = pickOneHot_s;
                        ownerNext_s = pickIdx_s;
                        holdNext_s  = HOLD_ONE;
                    end else begin
                        stateNext_s = ST_IDLE;
                        grantNext_s = {NUM_SRC{1'b0}};
                        holdNext_s  = HOLD_ZERO;
                    end
                end else if (!otherReq_s) begin
                    holdNext_s = (hold_r < HOLD_MAX_C) ? hold_r + HOLD_ONE : HOLD_MAX_C;
                end else if (hold_r < HOLD_MAX_C) begin
                    holdNext_s = hold_r + HOLD_ONE;
                end else begin
                    // Hold budget spent with others waiting: hand over, owner excluded.
                    grantNext_s = pickOneHot_s;
                    ownerNext_s = pickIdx_s;
                    ptrNext_s   = ownerPlusOne_s;
                    holdNext_s  = HOLD_ONE;
                end
            end
            default: begin
                stateNext_s = ST_IDLE;
                grantNext_s = {NUM_SRC{1'b0}};
                ownerNext_s = PTR_ZERO;
                ptrNext_s   = PTR_ZERO;
                holdNext_s  = HOLD_ZERO;
            end
        endcase
    end

    // Bus word of the next owner; the last word is held while no one is granted.
    always_comb begin
        validNext_s = (stateNext_s == ST_GRANT);
        dataNext_s  = data_r;
        if (validNext_s) begin
            dataNext_s = {DATAWIDTH_BUS{1'b0}};
            for (int j = 0; j < NUM_SRC; j++) begin
                dataNext_s = dataNext_s |
                    (SC_BUSARB_Data_In[j*DATAWIDTH_BUS +: DATAWIDTH_BUS] & {DATAWIDTH_BUS{grantNext_s[j]}});
            end
        end else begin
            dataNext_s = data_r;
        end
    end

    // State, pointer, counter and registered outputs.
    always_ff @(posedge SC_BUSARB_CLOCK_50 or negedge SC_BUSARB_RESET_InLow) begin
        if (!SC_BUSARB_RESET_InLow) begin
            state_r <= ST_IDLE;
            grant_r <= {NUM_SRC{1'b0}};
            owner_r <= PTR_ZERO;
            ptr_r   <= PTR_ZERO;
            hold_r  <= HOLD_ZERO;
            valid_r <= 1'b0;
            data_r  <= {DATAWIDTH_BUS{1'b0}};
        end else begin
            state_r <= stateNext_s;
            grant_r <= grantNext_s;
            owner_r <= ownerNext_s;
            ptr_r   <= ptrNext_s;
            hold_r  <= holdNext_s;
            valid_r <= validNext_s;
            data_r  <= dataNext_s;
        end
    end

    assign SC_BUSARB_Grant_Out   = grant_r;
    assign SC_BUSARB_Valid_Out   = valid_r;
    assign SC_BUSARB_DataBUS_Out = data_r;

endmodule

// File: tb/tb_sc_bus_arbiter.sv
// Scoreboard bench for sc_bus_arbiter: stimulus pushes the reference
// model's expected outputs, a monitor pops and compares after each edge.
module tb_sc_bus_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int HM = 4;

    logic              clk;
    logic              rst_n;
    logic [N-1:0]      req;
    logic [N*DW-1:0]   dataIn;
    logic [N-1:0]      grantOut;
    logic              validOut;
    logic [DW-1:0]     busOut;

    typedef struct {
        logic [N-1:0]  grant;
        logic          valid;
        logic [DW-1:0] data;
    } exp_t;

    exp_t expQ[$];
    int   checks   = 0;
    int   failures = 0;
    bit   checkEn  = 1'b0;

    // Reference model state: owner index (-1 = none), rr pointer, hold count, last bus word.
    int            mOwner = -1;
    int            mPtr   = 0;
    int            mHold  = 0;
    logic [DW-1:0] mData  = '0;

    sc_bus_arbiter #(
        .DATAWIDTH_BUS (DW),
        .NUM_SRC       (N),
        .HOLD_MAX      (HM)
    ) dut (
        .SC_BUSARB_CLOCK_50    (clk),
        .SC_BUSARB_RESET_InLow (rst_n),
        .SC_BUSARB_Req_In      (req),
        .SC_BUSARB_Data_In     (dataIn),
        .SC_BUSARB_Grant_Out   (grantOut),
        .SC_BUSARB_Valid_Out   (validOut),
        .SC_BUSARB_DataBUS_Out (busOut)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string name, input logic [DW-1:0] act, input logic [DW-1:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic int find_next(input logic [N-1:0] r, input int start, input int excl);
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (start + k) % N;
            if (r[idx] && idx != excl) return idx;
        end
        return -1;
    endfunction

    task automatic model_step(input logic [N-1:0] r, input logic [N*DW-1:0] d);
        exp_t e;
        int   nxt;
        bit   pre;
        bit   others;
        pre = 1'b0;
        if (mOwner < 0) begin
            nxt = find_next(r, mPtr, -1);
            if (nxt >= 0) begin
                mOwner = nxt;
                mHold  = 1;
            end
        end else begin
`ifdef SC_BUSARB_PREEMPT_EN
            pre = (mOwner != 0) && r[0];
`endif
            others = 1'b0;
            for (int i = 0; i < N; i++) if (i != mOwner && r[i]) others = 1'b1;
            if (pre) begin
                mOwner = 0;
                mHold  = 1;
            end else if (!r[mOwner]) begin
                mPtr   = (mOwner + 1) % N;
                mOwner = find_next(r, mPtr, -1);
                mHold  = (mOwner >= 0) ? 1 : 0;
            end else if (!others) begin
                mHold = (mHold < HM) ? mHold + 1 : HM;
            end else if (mHold < HM) begin
                mHold = mHold + 1;
            end else begin
                mPtr   = (mOwner + 1) % N;
                mOwner = find_next(r, mPtr, mOwner);
                mHold  = 1;
            end
        end
        e.grant = '0;
        e.valid = (mOwner >= 0);
        if (mOwner >= 0) begin
            e.grant[mOwner] = 1'b1;
            mData = d[mOwner*DW +: DW];
        end
        e.data = mData;
        expQ.push_back(e);
    endtask

    task automatic drive_cycle(input logic [N-1:0] r, input logic [N*DW-1:0] d);
        @(negedge clk);
        req    = r;
        dataIn = d;
        model_step(r, d);
        checkEn = 1'b1;
    endtask

    function automatic logic [N*DW-1:0] rand_data();
        logic [N*DW-1:0] v;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = $urandom;
        return v;
    endfunction

    // Monitor: after each edge compare DUT outputs with the oldest expectation.
    always @(posedge clk) begin
        #1;
        if (checkEn) begin
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_empty: got no expectation at %0t", $time);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                check_val("grant",  DW'(grantOut), DW'(e.grant));
                check_val("valid",  DW'(validOut), DW'(e.valid));
                check_val("bus",    busOut, e.data);
                check_val("onehot", DW'($onehot0(grantOut)), DW'(1));
            end
        end
    end

    initial begin
        logic [N*DW-1:0] d;
        logic [N-1:0]    r;

        // Reset held with all sources requesting.
        rst_n  = 1'b0;
        req    = 4'b1111;
        dataIn = rand_data();
        repeat (3) begin
            @(posedge clk);
            #1;
            check_val("rst_grant", DW'(grantOut), DW'(0));
            check_val("rst_valid", DW'(validOut), DW'(0));
            check_val("rst_bus",   busOut, 32'h0000_0000);
        end
        @(negedge clk);
        rst_n = 1'b1;
        req   = 4'b0000;

        // Single requester, then drop.
        d = rand_data();
        d[2*DW +: DW] = 32'hA5A5_0002;
        drive_cycle(4'b0100, d);
        drive_cycle(4'b0100, d);
        drive_cycle(4'b0000, rand_data());
        drive_cycle(4'b0000, rand_data());

        // All sources requesting: strict rotation.
        for (int c = 0; c < 20; c++) drive_cycle(4'b1111, rand_data());

        // Asynchronous reset in the middle of a grant.
        @(posedge clk);
        #3;
        checkEn = 1'b0;
        rst_n   = 1'b0;
        #1;
        check_val("midrst_grant", DW'(grantOut), DW'(0));
        check_val("midrst_valid", DW'(validOut), DW'(0));
        check_val("midrst_bus",   busOut, 32'h0000_0000);
        expQ.delete();
        mOwner = -1;
        mPtr   = 0;
        mHold  = 0;
        mData  = '0;
        @(negedge clk);
        req   = 4'b0000;
        rst_n = 1'b1;

        // Early release: source 0 drops after 2 cycles.
        drive_cycle(4'b0011, rand_data());
        drive_cycle(4'b0011, rand_data());
        drive_cycle(4'b0010, rand_data());
        drive_cycle(4'b0010, rand_data());

        // Data tracking on source 1.
        for (int k = 1; k <= 6; k++) begin
            d = rand_data();
            d[1*DW +: DW] = DW'(k);
            drive_cycle(4'b0010, d);
        end
        drive_cycle(4'b0000, rand_data());

        // Source 2 granted, then source 0 raises its request.
        drive_cycle(4'b0100, rand_data());
        for (int c = 0; c < 6; c++) drive_cycle(4'b0101, rand_data());
        drive_cycle(4'b0000, rand_data());

        // Randomized phase with sticky requests.
        r = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) if ($urandom_range(0, 3) == 0) r[i] = ~r[i];
            drive_cycle(r, rand_data());
        end

        // Drain the scoreboard.
        @(posedge clk);
        #2;
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", expQ.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sc_bus_arbiter.md
Name: sc_bus_arbiter

Overview:
Round-robin arbiter and registered bus driver sitting directly upstream of the datapath bus. Up to NUM_SRC register/ALU sources raise requests with their data words. The arbiter grants one source at a time and drives that source's data, registered, onto the bus input. A source holds the bus for at most HOLD_MAX consecutive cycles while others wait, so no source starves.

Parameters:
DATAWIDTH_BUS, 32, width of bus data word
NUM_SRC, 4, number of requesting sources (2..8)
HOLD_MAX, 4, max consecutive granted cycles while another source requests (1..15)

Ports:
SC_BUSARB_CLOCK_50  in  1  system clock, rising edge
SC_BUSARB_RESET_InLow  in  1  asynchronous active-low reset
SC_BUSARB_Req_In  in  NUM_SRC  per-source request, bit i = source i
SC_BUSARB_Data_In  in  NUM_SRC*DATAWIDTH_BUS  packed source data, slice i = source i
SC_BUSARB_Grant_Out  out  NUM_SRC  one-hot grant, registered
SC_BUSARB_Valid_Out  out  1  bus data valid, registered
SC_BUSARB_DataBUS_Out  out  DATAWIDTH_BUS  registered bus word, feeds bus input

Behaviour:
- One clock; reset is asynchronous and active-low. While SC_BUSARB_RESET_InLow=0: Grant_Out=0, Valid_Out=0, DataBUS_Out=0, state=IDLE, hold_cnt=0, rr_ptr=0.
- State IDLE: no grant. If any Req_In bit=1 at an edge, grant the first requester found searching from rr_ptr upward (wrapping modulo NUM_SRC). Go to GRANT, hold_cnt=1.
- State GRANT (owner g):
  - Req_In[g]=0: release. rr_ptr=g+1 mod NUM_SRC. If another request is present in the same edge, grant the next requester from rr_ptr, hold_cnt=1. Otherwise go to IDLE.
  - Req_In[g]=1 with no other request: keep grant; hold_cnt saturates at HOLD_MAX.
  - Req_In[g]=1, another request present, hold_cnt<HOLD_MAX: keep grant, hold_cnt+1.
  - Req_In[g]=1, another request present, hold_cnt=HOLD_MAX: rotate to the next requester after g (never g itself). rr_ptr=g+1, hold_cnt=1.
- Latency: request sampled at edge n gives Grant_Out and Valid_Out at edge n. Both are visible the cycle after Req_In rises.
- Data path: at each edge, DataBUS_Out <= Data_In slice of the next-grant owner. Data therefore has 1-cycle latency relative to Data_In and stays aligned with Grant_Out.
- When there is no next grant: Valid_Out=0 and DataBUS_Out holds its last value. Consumers qualify data with Valid_Out.
- Valid_Out = (next state == GRANT). Grant_Out is always one-hot or zero.
- Boundaries:
  - All sources requesting continuously: strict rotation 0→1→2→3→0, each holding HOLD_MAX cycles.
  - rr_ptr wraps from NUM_SRC-1 to 0.
  - Reset asserted mid-grant clears everything immediately, without waiting for a clock edge.
  - Reset deassertion takes effect at the next edge.
  - Req_In bits with index ≥NUM_SRC do not exist.
- hold_cnt width = clog2(HOLD_MAX+1).

Optional Feature:
SC_BUSARB_PREEMPT_EN:
- Defined: source 0 is high-priority. If Req_In[0]=1 while another source owns the bus, the grant moves to source 0 at the next edge, regardless of hold_cnt. hold_cnt=1 and rr_ptr is unchanged. The preempted source re-competes normally.
- Not defined: pure round-robin as above; source 0 has no special rights.

Decomposition:
- Shared package sc_busarb_pkg holds:
  - state encoding constants ST_IDLE=1'b0, ST_GRANT=1'b1;
  - a clog2 function for the counter and pointer widths.
- One natural sub-module: sc_busarb_rr_pick, a combinational find-first-set from rr_ptr with wrap. Inputs are request vector, pointer and exclude mask; outputs are one-hot next and found flag.
- Top holds the FSM, counter, pointer and data register.

Test Plan:
1. Reset: hold RESET_InLow=0 with Req_In=4'b1111 → Grant_Out=0, Valid_Out=0, DataBUS_Out=0. Assert reset mid-grant → all outputs 0 with no clock edge needed.
2. Single requester: Req_In=4'b0100, Data_In slice2=32'hA5A5_0002 → the next cycle gives Grant_Out=4'b0100, Valid_Out=1, DataBUS_Out=32'hA5A5_0002. Drop the request → Valid_Out=0 next cycle, data held.
3. Fairness: Req_In=4'b1111 held 20 cycles with HOLD_MAX=4 → grants 0,1,2,3 for 4 cycles each, then back to 0. Never two bits set in Grant_Out.
4. Early release: Req_In=4'b0011; source 0 drops after 2 cycles → grant moves to 1 on the next edge, with no idle cycle.
5. Data tracking: source 1 granted and changing data every cycle (1,2,3…) → DataBUS_Out follows with exactly 1-cycle lag.
6. With SC_BUSARB_PREEMPT_EN: source 2 granted with hold_cnt=1, then Req_In[0] rises → Grant_Out=4'b0001 next cycle. Without the macro, source 2 keeps the grant until HOLD_MAX.
